dcache_wb: RTL
==============

Name: dcache_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache between mips_core's data port and data_ram.
- Core side: responder on the ren/wen/addr/din/dout/stall interface, stalling the pipeline on misses.
- Memory side: initiator on the same ren/wen/addr/din/dout/ack handshake that data_ram answers, issuing one word per transfer.

Parameters:
- LINE_WORDS, 4, words per line (power of 2, ≥2); offset = addr[log2(LINE_WORDS)+1:2].
- LINE_NUM, 64, number of lines (power of 2); index bits sit directly above offset.
- TAG_W, 32-2-log2(LINE_WORDS)-log2(LINE_NUM) (=22 default), tag width, derived, not overridable.

Ports:
- clk  in  1  main clock
- rst  in  1  synchronous reset, active-high
- cpu_ren  in  1  core load request
- cpu_wen  in  1  core store request
- cpu_addr  in  32  core byte address; bits[1:0] ignored
- cpu_din  in  32  store data from core
- cpu_dout  out  32  load data to core
- cpu_stall  out  1  request not yet satisfied; core holds request stable while high
- mem_ren  out  1  word read request to data_ram
- mem_wen  out  1  word write request to data_ram
- mem_addr  out  32  word-aligned byte address, bits[1:0]=0
- mem_dout  out  32  write data to data_ram
- mem_din  in  32  read data from data_ram, valid with mem_ack
- mem_ack  in  1  data_ram completed current word (may be same cycle as request)

Behaviour:
- Storage per line: valid, dirty, tag[TAG_W], LINE_WORDS×32 data.
- Reset (synchronous, rst=1 at posedge): all valid/dirty cleared, state=IDLE, word counter=0.
- While rst=1: cpu_stall=0, mem_ren=0, mem_wen=0, mem_addr=0, mem_dout=0, cpu_dout=0.
- Reset mid-miss: in-flight memory word abandoned (requests drop next cycle); dirty data discarded.
- hit = valid[idx] & tag[idx]==cpu_addr tag.
- req = cpu_ren|cpu_wen. If both are high, the access is treated as a store.
- States: IDLE, WRITEBACK, REFILL.
- IDLE, req & hit:
  - cpu_stall=0.
  - Load: cpu_dout = line word, combinational, same cycle.
  - Store: word written and dirty set at posedge.
- IDLE, req & miss:
  - cpu_stall=1 combinationally.
  - At posedge, latch victim tag, counter=0.
  - Go to WRITEBACK if valid&dirty, else REFILL.
- IDLE, no req: cpu_stall=0; cpu_dout=0 when ren=0.
- WRITEBACK:
  - mem_wen=1, mem_addr={victim_tag,idx,cnt,2'b00}, mem_dout=line word cnt.
  - Outputs held until mem_ack.
  - On ack: cnt++. Ack on last word → cnt=0, REFILL.
  - cpu_stall=1.
- REFILL:
  - mem_ren=1, mem_addr={req_tag,idx,cnt,2'b00}.
  - On ack, mem_din written to word cnt, cnt++.
  - On last ack: tag=req_tag, valid=1, dirty=0, → IDLE.
  - cpu_stall=1.
- Return to IDLE: the held request re-evaluates as a hit, so a store completes then and stall drops.
- Latency with single-cycle ack (ack same cycle as request):
  - Clean miss: stall high 1+LINE_WORDS cycles (5).
  - Dirty miss: 1+2×LINE_WORDS cycles (9).
- mem_ren and mem_wen are never high together; both are 0 in IDLE.
- Counter wraps to 0 on the last word; no other wrap.
- mem_ack in IDLE is ignored.
- Core must not change cpu_addr/cpu_din while cpu_stall=1. Changed inputs are undefined behaviour; the refill still completes for the latched tag.

Optional Feature:
- Macro DCACHE_STAT_EN.
- Defined: adds output ports stat_hit[31:0] and stat_miss[31:0], both cleared by rst.
  - stat_miss increments once per miss, at the IDLE→WRITEBACK/REFILL transition.
  - stat_hit increments each IDLE cycle with req & hit & ~cpu_stall.
  - The post-refill completion cycle counts as a hit.
  - Counters saturate at 32'hFFFFFFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- After rst, load 0x00000040, memory model with same-cycle ack returning 0x1000+wordaddr → exact mem_ren sequence:
  - cpu_stall high 5 cycles; mem_ren addresses 0x40, 0x44, 0x48, 0x4C.
  - Then cpu_dout=0x1010, stall=0.
  - Re-load 0x48 → dout 0x1012 with no stall.
- Store 0xDEADBEEF to 0x44 (line resident) → no stall, no mem traffic. Load 0x44 → 0xDEADBEEF.
- Conflicting load 0x00000440 (same index, different tag) after dirty store → stall 9 cycles:
  - mem_wen addresses 0x40..0x4C, with mem_dout at 0x44 = 0xDEADBEEF.
  - Then mem_ren addresses 0x440..0x44C.
- Memory model with 3-cycle ack delay on clean miss → each mem_ren/mem_addr held 3 cycles; total stall 1+4×3=13 cycles.
- rst asserted during 2nd REFILL word:
  - Next cycle mem_ren=0, stall=0.
  - Re-load of the same address performs a full 4-word refill (line invalid).
- With DCACHE_STAT_EN: clean-miss load, two hit loads, one hit store → stat_miss=1, stat_hit=4 (completion cycle + 3).

Source files
------------

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache between core and data_ram.
// Define DCACHE_STAT_EN to add saturating hit/miss counters (stat_hit, stat_miss).
module dcache_wb #(
  parameter int LINE_WORDS = 4,
  parameter int LINE_NUM   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ren,
  input  logic        cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        cpu_stall,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dout,
  input  logic [31:0] mem_din,
  input  logic        mem_ack
`ifdef DCACHE_STAT_EN
  ,
  output logic [31:0] stat_hit,
  output logic [31:0] stat_miss
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINE_NUM);
  localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } state_t;

  state_t state, state_n;

  logic [IDX_W-1:0] idx, idx_q;
  logic [OFF_W-1:0] off, cnt;
  logic [TAG_W-1:0] atag, victim_tag, req_tag;

  logic [LINE_NUM-1:0] valid, dirty;
  logic [TAG_W-1:0]    tags [LINE_NUM];
  logic [31:0]         data [LINE_NUM][LINE_WORDS];

  logic req, hit, idle_hit, st_hit, miss_go;
  logic xfer_ack, fill_ack, fill_done;
  logic unused_lsb;

  assign idx  = cpu_addr[2+OFF_W +: IDX_W];
  assign off  = cpu_addr[2 +: OFF_W];
  assign atag = cpu_addr[31 -: TAG_W];
  assign unused_lsb = ^cpu_addr[1:0];

  assign req = cpu_ren | cpu_wen;
  assign hit = valid[idx] && (tags[idx] == atag);

  assign idle_hit  = (state == IDLE) && req && hit;
  assign st_hit    = idle_hit && cpu_wen;
  assign miss_go   = (state == IDLE) && req && !hit;
  assign xfer_ack  = (state != IDLE) && mem_ack;
  assign fill_ack  = (state == REFILL) && mem_ack;
  assign fill_done = fill_ack && (cnt == LAST);

  always_comb begin
    state_n   = state;
    cpu_stall = 1'b0;
    cpu_dout  = '0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_dout  = '0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              if (!cpu_wen) cpu_dout = data[idx][off];
            end else begin
              cpu_stall = 1'b1;
              state_n = (valid[idx] && dirty[idx]) ?
                        WRITEBACK : REFILL;
            end
          end
        end
        WRITEBACK: begin
          cpu_stall = 1'b1;
          mem_wen   = 1'b1;
          mem_addr  = {victim_tag, idx_q, cnt, 2'b00};
          mem_dout  = data[idx_q][cnt];
          if (mem_ack && cnt == LAST) state_n = REFILL;
        end
        REFILL: begin
          cpu_stall = 1'b1;
          mem_ren   = 1'b1;
          mem_addr  = {req_tag, idx_q, cnt, 2'b00};
          if (mem_ack && cnt == LAST) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= state_n;
      if (miss_go) cnt <= '0;
      else if (xfer_ack) cnt <= cnt + 1'b1;
      if (st_hit) dirty[idx] <= 1'b1;
      if (fill_done) begin
        valid[idx_q] <= 1'b1;
        dirty[idx_q] <= 1'b0;
      end
    end
  end

  // Line storage and miss context carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (st_hit) data[idx][off] <= cpu_din;
      if (miss_go) begin
        victim_tag <= tags[idx];
        req_tag    <= atag;
        idx_q      <= idx;
      end
      if (fill_ack) data[idx_q][cnt] <= mem_din;
      if (fill_done) tags[idx_q] <= req_tag;
    end
  end

`ifdef DCACHE_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hit  <= '0;
      stat_miss <= '0;
    end else begin
      if (idle_hit && stat_hit != '1)
        stat_hit <= stat_hit + 32'd1;
      if (miss_go && stat_miss != '1)
        stat_miss <= stat_miss + 32'd1;
    end
  end
`endif

endmodule
